burst_mem_responder: RTL and testbench

- Synthesizable responder for the physical-memory burst interface that the mp4 top drives through pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp.
- Backs a line-organised array, inserts a programmable access latency, and transfers each 256-bit cache line as BURST_LEN 64-bit beats.
- Used as on-chip/FPGA memory and as the reference responder in standalone cache and L2 benches.
- Exposes access counters for performance measurement.

---
 rtl/burst_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_burst_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Line-organised memory that answers physical-memory burst requests after a fixed latency.
// Each line moves as BURST_LEN beats of DATA_W bits; completed bursts are counted per direction.
module burst_mem_responder #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned LATENCY     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              proto_err,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
);

  localparam int unsigned OffW  = $clog2(DATA_W * BURST_LEN / 8);
  localparam int unsigned IdxW  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LatW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LatW-1:0]  LatInit  = LatW'(LATENCY - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

  state_e            state_q, state_d;
  logic              op_write_q, op_write_d;
  logic [IdxW-1:0]   line_q, line_d;
  logic [31:0]       addr_q, addr_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              addr_err_q, addr_err_d;
  logic              err_q, err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] rdata_q;

  logic              req_held;
  logic              addr_mismatch;
  logic              rd_load;
  logic [BeatW-1:0]  rd_beat;
  logic              wr_en;

  logic [DATA_W-1:0] mem_q [DEPTH_LINES][BURST_LEN];

  // Only the request matching the latched op keeps a burst alive.
  assign req_held      = op_write_q ? mem_write : mem_read;
  // An address change is reported once per burst; addr_err_q remembers it was already flagged.
  assign addr_mismatch = (mem_address != addr_q) && !addr_err_q;

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    line_d     = line_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    addr_err_d = addr_err_q;
    err_d      = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_load    = 1'b0;
    rd_beat    = '0;
    wr_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          op_write_d = !mem_read;
          line_d     = mem_address[OffW +: IdxW];
          addr_d     = mem_address;
          lat_d      = LatInit;
          beat_d     = '0;
          addr_err_d = 1'b0;
          err_d      = mem_read && mem_write;
          state_d    = StWait;
        end
      end

      StWait: begin
        if (!req_held) begin
          err_d   = 1'b1;
          lat_d   = '0;
          state_d = StIdle;
        end else begin
          if (addr_mismatch) begin
            err_d      = 1'b1;
            addr_err_d = 1'b1;
          end
          if (lat_q == '0) begin
            beat_d  = '0;
            rd_load = !op_write_q;
            rd_beat = '0;
            state_d = StBurst;
          end else begin
            lat_d = lat_q - 1'b1;
          end
        end
      end

      StBurst: begin
        if (!req_held) begin
          // Beats already written stay in the array; nothing is counted.
          err_d   = 1'b1;
          beat_d  = '0;
          state_d = StIdle;
        end else begin
          if (addr_mismatch) begin
            err_d      = 1'b1;
            addr_err_d = 1'b1;
          end
          wr_en = op_write_q;
          if (beat_q == BeatLast) begin
            beat_d  = '0;
            state_d = StDone;
            if (op_write_q) begin
              wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
              rd_cnt_d = rd_cnt_q + 32'd1;
            end
          end else begin
            beat_d  = beat_q + 1'b1;
            rd_load = !op_write_q;
            rd_beat = beat_q + 1'b1;
          end
        end
      end

      StDone: begin
        if (!mem_read && !mem_write) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      line_q     <= '0;
      addr_q     <= '0;
      lat_q      <= '0;
      beat_q     <= '0;
      addr_err_q <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      addr_err_q <= addr_err_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      if (rd_load) begin
        rdata_q <= mem_q[line_q][rd_beat];
      end
    end
  end

  // Storage is never cleared; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[line_q][beat_q] <= mem_wdata;
    end
  end

  assign mem_resp    = (state_q == StBurst);
  assign mem_rdata   = rdata_q;
  assign proto_err   = err_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (latency 10 and 1) driven burst by burst,
// read data checked against a bench-side line model through an expected-beat queue.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        mem_read_v    [2];
  logic        mem_write_v   [2];
  logic [31:0] mem_address_v [2];
  logic [63:0] mem_wdata_v   [2];
  logic [63:0] mem_rdata_v   [2];
  logic        mem_resp_v    [2];
  logic        proto_err_v   [2];
  logic [31:0] read_count_v  [2];
  logic [31:0] write_count_v [2];

  logic [63:0] model [2][256][4];
  logic [63:0] exp_q [$];
  int unsigned exp_rd [2];
  int unsigned exp_wr [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .DATA_W(64), .BURST_LEN(4), .DEPTH_LINES(256), .LATENCY(10)
  ) dut0 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
    .mem_address(mem_address_v[0]), .mem_wdata(mem_wdata_v[0]),
    .mem_rdata(mem_rdata_v[0]), .mem_resp(mem_resp_v[0]), .proto_err(proto_err_v[0]),
    .read_count(read_count_v[0]), .write_count(write_count_v[0])
  );

  burst_mem_responder #(
    .DATA_W(64), .BURST_LEN(4), .DEPTH_LINES(256), .LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
    .mem_address(mem_address_v[1]), .mem_wdata(mem_wdata_v[1]),
    .mem_rdata(mem_rdata_v[1]), .mem_resp(mem_resp_v[1]), .proto_err(proto_err_v[1]),
    .read_count(read_count_v[1]), .write_count(write_count_v[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_counts(input int d);
    check_eq("read_count", 64'(read_count_v[d]), 64'(exp_rd[d]));
    check_eq("write_count", 64'(write_count_v[d]), 64'(exp_wr[d]));
  endtask

  // Runs one burst on instance d. cut >= 0 drops the request (or asserts reset when
  // cut_rst) in the cycle beat `cut` is seen, so that beat is never committed.
  task automatic run_burst(input int d, input bit wr, input logic [31:0] addr,
                           input logic [63:0] w0, input logic [63:0] w1,
                           input logic [63:0] w2, input logic [63:0] w3,
                           input bit both, input int cut, input bit cut_rst);
    logic [63:0] wb [4];
    logic [63:0] exp_d;
    int          lat, line, k, beats;
    bit          done;
    wb    = '{w0, w1, w2, w3};
    lat   = (d == 0) ? 10 : 1;
    line  = int'((addr >> 5) % 256);
    if (!wr) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(model[d][line][i]);
    end
    mem_address_v[d] = addr;
    mem_read_v[d]    = !wr;
    mem_write_v[d]   = wr || both;
    mem_wdata_v[d]   = wb[0];
    k     = -1;
    beats = 0;
    done  = 1'b0;
    while (!done && k < lat + 40) begin
      @(negedge clk);
      k++;
      if (k == 0) check_eq("proto_err_accept", 64'(proto_err_v[d]), 64'(both));
      if (mem_resp_v[d]) begin
        check_eq("resp_cycle", 64'(k), 64'(lat + beats));
        if (!wr) begin
          check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            check_eq("rdata", mem_rdata_v[d], exp_d);
          end
        end else begin
          mem_wdata_v[d] = wb[beats];
        end
        if (beats == cut) begin
          mem_read_v[d]  = 1'b0;
          mem_write_v[d] = 1'b0;
          if (cut_rst) rst = 1'b0;
          done = 1'b1;
        end else begin
          if (wr) model[d][line][beats] = wb[beats];
          beats++;
          if (beats == 4) done = 1'b1;
        end
      end
    end
    check_eq("burst_reached_end", 64'(done), 64'd1);

    if (cut < 0) begin
      if (wr) exp_wr[d]++;
      else    exp_rd[d]++;
      // Request stays high in DONE: no new burst, no error, counters bumped once.
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        check_eq("done_no_resp", 64'(mem_resp_v[d]), 64'd0);
        check_eq("done_no_err", 64'(proto_err_v[d]), 64'd0);
        check_counts(d);
      end
      if (!wr) check_eq("rdata_hold", mem_rdata_v[d], model[d][line][3]);
      mem_read_v[d]  = 1'b0;
      mem_write_v[d] = 1'b0;
      @(negedge clk);
    end else if (!cut_rst) begin
      exp_q.delete();
      @(negedge clk);
      check_eq("abort_err", 64'(proto_err_v[d]), 64'd1);
      check_eq("abort_resp", 64'(mem_resp_v[d]), 64'd0);
      check_counts(d);
      @(negedge clk);
      check_eq("abort_err_pulse", 64'(proto_err_v[d]), 64'd0);
    end else begin
      exp_q.delete();
      @(negedge clk);
      exp_rd = '{0, 0};
      exp_wr = '{0, 0};
      check_eq("rst_resp", 64'(mem_resp_v[d]), 64'd0);
      check_eq("rst_rdata", mem_rdata_v[d], 64'd0);
      check_eq("rst_err", 64'(proto_err_v[d]), 64'd0);
      check_counts(d);
      rst = 1'b1;
      @(negedge clk);
    end
    mem_wdata_v[d] = '0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_read_v[d]    = 1'b0;
      mem_write_v[d]   = 1'b0;
      mem_address_v[d] = '0;
      mem_wdata_v[d]   = '0;
      exp_rd[d]        = 0;
      exp_wr[d]        = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_resp", 64'(mem_resp_v[d]), 64'd0);
      check_eq("reset_rdata", mem_rdata_v[d], 64'd0);
      check_eq("reset_err", 64'(proto_err_v[d]), 64'd0);
      check_counts(d);
    end
    rst = 1'b1;
    @(negedge clk);

    // Write then read, latency 10
    run_burst(0, 1'b1, 32'h0000_0040, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}},
              1'b0, -1, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0040, '0, '0, '0, '0, 1'b0, -1, 1'b0);

    // Address wrap: 0x2000 aliases line 0
    run_burst(0, 1'b1, 32'h0000_2000, 64'hDEAD_BEEF_0000_0000, {16{4'h5}}, {16{4'h6}},
              {16{4'h7}}, 1'b0, -1, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0000, '0, '0, '0, '0, 1'b0, -1, 1'b0);

    // Simultaneous read and write: read wins, error pulse at acceptance
    run_burst(0, 1'b0, 32'h0000_0040, '0, '0, '0, '0, 1'b1, -1, 1'b0);

    // Write aborted after two beats, then read back mixed line
    run_burst(0, 1'b1, 32'h0000_0040, {16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}},
              1'b0, 2, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0040, '0, '0, '0, '0, 1'b0, -1, 1'b0);

    // Latency 1 instance
    run_burst(1, 1'b1, 32'h0000_0060, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h8000_0000_0000_0001, 1'b0, -1, 1'b0);
    run_burst(1, 1'b0, 32'h0000_0060, '0, '0, '0, '0, 1'b0, -1, 1'b0);
    run_burst(1, 1'b0, 32'h0000_0060, '0, '0, '0, '0, 1'b0, -1, 1'b0);

    // Reset during beat 1 of a read; array contents must survive
    run_burst(0, 1'b0, 32'h0000_2000, '0, '0, '0, '0, 1'b0, 1, 1'b1);
    run_burst(0, 1'b0, 32'h0000_0040, '0, '0, '0, '0, 1'b0, -1, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0000, '0, '0, '0, '0, 1'b0, -1, 1'b0);
    run_burst(1, 1'b0, 32'h0000_0060, '0, '0, '0, '0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
